// File: rtl/seq_divider_if.sv
// ============================================================================
//  Module   : seq_divider_if
//  Brief    : Start/busy/done handshake and operand/result bundle for seq_divider.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface seq_divider_if #(
    parameter int DW = 17,
    parameter int VW = 8
);
    logic          iSTART;
    logic [DW-1:0] iDIVIDEND;
    logic [VW-1:0] iDIVISOR;
    logic          oBUSY;
    logic          oDONE;
    logic [DW-1:0] oQUOT;
    logic [VW-1:0] oREM;
    logic          oDIV0;

    modport master (
        output iSTART, iDIVIDEND, iDIVISOR,
        input  oBUSY, oDONE, oQUOT, oREM, oDIV0
    );

    modport slave (
        input  iSTART, iDIVIDEND, iDIVISOR,
        output oBUSY, oDONE, oQUOT, oREM, oDIV0
    );
endinterface

`default_nettype wire

// File: rtl/seq_divider.sv
// ============================================================================
//  Module   : seq_divider
//  Brief    : Multi-cycle restoring divider, one quotient bit per clock.
//             Define SEQ_DIVIDER_SIGNED_EN for two's-complement operation.
//  Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module seq_divider #(
    parameter int DW = 17,
    parameter int VW = 8
) (
    input  logic        iCLK,
    input  logic        iRST,
    seq_divider_if.slave bus
);
    localparam int             CW         = (DW > 1) ? $clog2(DW) : 1;
    localparam logic [CW-1:0]  c_CNT_LOAD = CW'(DW - 1);
    localparam logic [CW-1:0]  c_CNT_ONE  = CW'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_RUN  = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    logic [1:0]    r_state;
    logic [DW-1:0] r_shift;
    logic [VW-1:0] r_rem;
    logic [VW-1:0] r_div;
    logic [CW-1:0] r_cnt;
    logic          r_div0;
    logic          r_busy;
    logic          r_done;
    logic [DW-1:0] r_quot;
    logic [VW-1:0] r_remOut;
    logic          r_div0Out;
`ifdef SEQ_DIVIDER_SIGNED_EN
    logic          r_qNeg;
    logic          r_rNeg;
`endif

    logic [DW-1:0] w_dvdIn;
    logic [VW-1:0] w_dvsIn;
    logic [VW:0]   w_trial;
    logic [VW+1:0] w_sub;
    logic          w_qbit;
    logic [VW-1:0] w_remNext;
    logic [DW-1:0] w_qFinal;
    logic [DW-1:0] w_quotRes;
    logic [VW-1:0] w_remRes;

    // Operands enter the core as magnitudes; the core itself is always unsigned.
    always_comb begin
        w_dvdIn = bus.iDIVIDEND;
        w_dvsIn = bus.iDIVISOR;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (bus.iDIVIDEND[DW-1]) w_dvdIn = -bus.iDIVIDEND;
        if (bus.iDIVISOR[VW-1])  w_dvsIn = -bus.iDIVISOR;
`endif
    end

    // A kept remainder is always below the divisor, so VW bits hold it either way.
    always_comb begin
        w_trial   = {r_rem, r_shift[DW-1]};
        w_sub     = {1'b0, w_trial} - {2'b00, r_div};
        w_qbit    = ~w_sub[VW+1];
        w_remNext = w_qbit ? w_sub[VW-1:0] : w_trial[VW-1:0];
        w_qFinal  = {r_shift[DW-2:0], w_qbit};
    end

    always_comb begin
        w_quotRes = w_qFinal;
        w_remRes  = w_remNext;
`ifdef SEQ_DIVIDER_SIGNED_EN
        if (r_qNeg) w_quotRes = -w_qFinal;
        if (r_rNeg) w_remRes  = -w_remNext;
`endif
        if (r_div0) begin
            w_quotRes = '1;
            w_remRes  = '0;
        end
    end

    always_ff @(posedge iCLK or posedge iRST) begin
        if (iRST) begin
            r_state   <= c_IDLE;
            r_shift   <= '0;
            r_rem     <= '0;
            r_div     <= '0;
            r_cnt     <= '0;
            r_div0    <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_quot    <= '0;
            r_remOut  <= '0;
            r_div0Out <= 1'b0;
`ifdef SEQ_DIVIDER_SIGNED_EN
            r_qNeg    <= 1'b0;
            r_rNeg    <= 1'b0;
`endif
        end else begin
            case (r_state)
                c_IDLE: begin
                    if (bus.iSTART) begin
                        r_state <= c_RUN;
                        r_shift <= w_dvdIn;
                        r_div   <= w_dvsIn;
                        r_rem   <= '0;
                        r_cnt   <= c_CNT_LOAD;
                        r_div0  <= (bus.iDIVISOR == '0);
                        r_busy  <= 1'b1;
`ifdef SEQ_DIVIDER_SIGNED_EN
                        r_qNeg  <= bus.iDIVIDEND[DW-1] ^ bus.iDIVISOR[VW-1];
                        r_rNeg  <= bus.iDIVIDEND[DW-1];
`endif
                    end
                end
                c_RUN: begin
                    r_shift <= w_qFinal;
                    r_rem   <= w_remNext;
                    if (r_cnt == '0) begin
                        r_state   <= c_DONE;
                        r_done    <= 1'b1;
                        r_quot    <= w_quotRes;
                        r_remOut  <= w_remRes;
                        r_div0Out <= r_div0;
                    end else begin
                        r_cnt <= r_cnt - c_CNT_ONE;
                    end
                end
                c_DONE: begin
                    r_state <= c_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= c_IDLE;
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.oBUSY = r_busy;
    assign bus.oDONE = r_done;
    assign bus.oQUOT = r_quot;
    assign bus.oREM  = r_remOut;
    assign bus.oDIV0 = r_div0Out;

endmodule

`default_nettype wire
